// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The master side issues operations; the slave side is the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow register. Operands are
// captured when a start is accepted (IDLE or DONE); the result and borrow-out
// are published together with a one-cycle done pulse and held until the next
// completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             br_next;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             x, y, z, d;
  logic             accept;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs; the new difference bit enters the result at the MSB
  always_comb begin
    x        = op_a[0];
    y        = op_b[0];
    z        = br;
    d        = x ^ y ^ z;
    br_next  = (~x & y) | (~x & z) | (y & z);
    res_next = res >> 1;
    res_next[WIDTH-1] = d;
  end

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == LAST);

  // State register; reset wins over any pending start
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; a start in DONE restarts with no dead cycle
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (accept) state_next = RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, serial shifting and result publication on the final bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      op_a <= bus.a;
      op_b <= bus.b;
      br   <= bus.bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      res  <= res_next;
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff_q <= res_next;
        bout_q <= br_next;
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes a - b - bin, least-significant bit first. It uses one full-subtractor cell and a borrow register, and processes one bit per clock. It is the inverse-direction companion to the team's combinational full adder. Datapaths that can trade latency for area use it in place of a parallel ripple subtractor, controlled through a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal values 1 to 32)

Ports:
clk  input  1  clock; all state changes on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
start  input  1  request pulse; accepted only when the block is ready (IDLE or DONE state)
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
bin  input  1  borrow-in; sampled on the accepting edge only
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse; diff and bout are valid in this cycle
diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH; held until the next completion
bout  output  1  borrow-out; 1 iff a < b + bin (unsigned comparison); held with diff

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state goes to IDLE; busy = 0, done = 0, diff = 0, bout = 0.
  - Internal shift registers, borrow register and bit counter are cleared.
  - Reset overrides start in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1: latch a into opA and b into opB, borrow register br <= bin, cnt <= 0, go to RUN.
  - start = 0: stay in IDLE.
- RUN, per cycle:
  - Inputs to the cell: x = opA[0], y = opB[0], z = br.
  - d = x ^ y ^ z.
  - br <= (~x & y) | (~x & z) | (y & z).
  - Result shift register: res <= {d, res[WIDTH-1:1]}, so bits enter at the MSB and the LSB ends up at bit 0.
  - opA and opB shift right by one.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1 (the last bit), go to DONE.
  - busy = 1 throughout RUN.
  - start is ignored in RUN; no queueing, no error flag.
- Transition into DONE:
  - diff <= final res including the last d.
  - bout <= final borrow.
  - done = 1 for exactly one cycle (the DONE cycle); busy = 0.
- DONE:
  - start = 1: accepted exactly as in IDLE; back-to-back operation with no dead cycle; go to RUN.
  - Otherwise go to IDLE.
- Latency:
  - start accepted at edge T; RUN covers edges T+1 through T+WIDTH.
  - done is high during the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
- Throughput: one result per WIDTH+1 cycles.
- Output hold rules:
  - diff and bout change only on entry to DONE or on reset.
  - During RUN they hold the previous result.
  - Input changes on a, b, bin after acceptance have no effect on the current operation.
- Counter width: clog2(WIDTH+1) bits, at least 1.
- WIDTH = 1: a single RUN cycle; the block reduces to a registered full subtractor.
- Reset mid-operation: abort the operation, clear all outputs, no done pulse; the next start behaves normally.

Test Plan:
- WIDTH=8, start with a=0x5A, b=0x23, bin=0 -> done exactly 9 cycles after the start cycle, diff=0x37, bout=0; busy high for 8 cycles.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- Start a=0x80, b=0x01; pulse start with a=0x00, b=0x00 on cycle 3 of RUN, and change the a/b inputs mid-run -> the mid-run start is ignored, the result is still diff=0x7F, bout=0, and exactly one done pulse occurs.
- Assert start in the done cycle with a=0x03, b=0x05, bin=0 -> the first result is held and the second operation starts with no idle cycle; second done after 9 more cycles with diff=0xFE, bout=1.
- Pull rst_n low for 1 cycle in the middle of an operation -> busy=0, done=0, diff=0, bout=0 on the next cycle; no done pulse follows; a subsequent start with 0x0A-0x04 gives diff=0x06, bout=0.
- WIDTH=1 instance, all 8 combinations of a, b, bin -> diff/bout match the full-subtractor truth table; done 2 cycles after each start.
